// File: rtl/serial_shifter_pkg.sv
// Shared types and constants for the sequential shifter and its step primitive.
package serial_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/serial_shifter_if.sv
// Request/result handshake bundle: master is the producer/consumer side, slave is the shifter.
interface serial_shifter_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             LR;
    logic             AL;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;

    modport master (
        output in_valid, din, shamt, LR, AL, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, shamt, LR, AL, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/serial_shifter_shift_step.sv
// Single-position shifter: logical left, logical right or arithmetic right by exactly one bit.
module serial_shifter_shift_step
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din_i,
    input  logic             lr_i,
    input  logic             al_i,
    output logic [WIDTH-1:0] dout_o
);

    logic fill_bit;

    always_comb begin
        // Right-shift fill is the sign bit only for arithmetic shifts
        fill_bit = al_i & din_i[WIDTH-1];
        if (lr_i == DIR_LEFT) begin
            dout_o = {din_i[WIDTH-2:0], 1'b0};
        end else begin
            dout_o = {fill_bit, din_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both request and result sides.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_shifter_if.slave bus
);

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             lr_q, lr_d;
    logic             al_q, al_d;
    logic [WIDTH-1:0] step_w;

    serial_shifter_shift_step #(.WIDTH(WIDTH)) u_step (
        .din_i  (work_q),
        .lr_i   (lr_q),
        .al_i   (al_q),
        .dout_o (step_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            lr_q    <= 1'b0;
            al_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        work_d        = work_q;
        lr_d          = lr_q;
        al_d          = al_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.dout      = work_q;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    work_d  = bus.din;
                    lr_d    = bus.LR;
                    al_d    = bus.AL;
                    cnt_d   = bus.shamt;
                    state_d = (bus.shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // Counter is never zero here, so the decrement cannot wrap
                work_d = step_w;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
